// File: rtl/pattern_gen.sv
// Multi-channel add/shift pattern generator with per-channel rate dividers and burst length.
// Optional macro PATGEN_SATURATE_EN: add mode saturates instead of wrapping.
module pattern_gen #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned DIV_WIDTH = 8,
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_start,
   input  logic                          i_stop,
   input  logic [CHANNELS-1:0]           i_mode,
   input  logic [CHANNELS*WIDTH-1:0]     i_seed,
   input  logic [CHANNELS*WIDTH-1:0]     i_step,
   input  logic [CHANNELS*DIV_WIDTH-1:0] i_div,
   input  logic [LEN_WIDTH-1:0]          i_len,
   output logic [CHANNELS*WIDTH-1:0]     o_data,
   output logic [CHANNELS-1:0]           o_valid,
   output logic                          o_busy,
   output logic                          o_done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t                        r_state;
   logic [CHANNELS-1:0]           r_mode;
   logic [CHANNELS*WIDTH-1:0]     r_seed;
   logic [CHANNELS*WIDTH-1:0]     r_step;
   logic [CHANNELS*DIV_WIDTH-1:0] r_div;
   logic [LEN_WIDTH-1:0]          r_len;
   logic [LEN_WIDTH-1:0]          r_samp;
   logic [DIV_WIDTH-1:0]          r_div_cnt [CHANNELS];

   logic [WIDTH-1:0]              w_next [CHANNELS];
   logic [WIDTH-1:0]              w_shr  [CHANNELS];
   logic                          w_hit  [CHANNELS];
`ifdef PATGEN_SATURATE_EN
   logic [WIDTH:0]                w_sum  [CHANNELS];
`endif

   always_comb begin
      for (int unsigned n = 0; n < CHANNELS; n++) begin
         w_hit[n] = (r_div_cnt[n] == r_div[n*DIV_WIDTH +: DIV_WIDTH]);
         w_shr[n] = o_data[n*WIDTH +: WIDTH] >> 1;
`ifdef PATGEN_SATURATE_EN
         w_sum[n] = {1'b0, o_data[n*WIDTH +: WIDTH]} + {1'b0, r_step[n*WIDTH +: WIDTH]};
`endif
         if (r_mode[n]) begin
            // Shift reloads the captured seed once the value would shift out to zero.
            w_next[n] = (w_shr[n] == '0) ? r_seed[n*WIDTH +: WIDTH] : w_shr[n];
         end else begin
`ifdef PATGEN_SATURATE_EN
            w_next[n] = w_sum[n][WIDTH] ? '1 : w_sum[n][WIDTH-1:0];
`else
            w_next[n] = o_data[n*WIDTH +: WIDTH] + r_step[n*WIDTH +: WIDTH];
`endif
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_mode  <= '0;
         r_seed  <= '0;
         r_step  <= '0;
         r_div   <= '0;
         r_len   <= '0;
         r_samp  <= '0;
         for (int unsigned n = 0; n < CHANNELS; n++) r_div_cnt[n] <= '0;
         o_data  <= '0;
         o_valid <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               o_valid <= '0;
               o_done  <= 1'b0;
               if (i_start && !i_stop) begin
                  r_mode  <= i_mode;
                  r_seed  <= i_seed;
                  r_step  <= i_step;
                  r_div   <= i_div;
                  r_len   <= i_len;
                  o_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (i_stop) begin
                  o_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  o_data  <= r_seed;
                  o_valid <= '1;
                  r_samp  <= LEN_WIDTH'(1);
                  for (int unsigned n = 0; n < CHANNELS; n++) r_div_cnt[n] <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (i_stop) begin
                  o_valid <= '0;
                  o_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_len != '0 && r_samp == r_len) begin
                  o_valid <= '0;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  for (int unsigned n = 0; n < CHANNELS; n++) begin
                     o_valid[n] <= w_hit[n];
                     if (w_hit[n]) begin
                        r_div_cnt[n]              <= '0;
                        o_data[n*WIDTH +: WIDTH] <= w_next[n];
                     end else begin
                        r_div_cnt[n] <= r_div_cnt[n] + DIV_WIDTH'(1);
                     end
                  end
                  if (w_hit[0] && r_samp != '1) r_samp <= r_samp + LEN_WIDTH'(1);
               end
            end
            S_DONE: begin
               o_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed self-checking bench for pattern_gen (2 channels, 8-bit data).
module tb_pattern_gen;

   localparam int unsigned WIDTH = 8, CHANNELS = 2, DIV_WIDTH = 8, LEN_WIDTH = 16;

   logic                          i_clk = 1'b0;
   logic                          i_rst = 1'b1;
   logic                          i_start = 1'b0;
   logic                          i_stop = 1'b0;
   logic [CHANNELS-1:0]           i_mode = '0;
   logic [CHANNELS*WIDTH-1:0]     i_seed = '0;
   logic [CHANNELS*WIDTH-1:0]     i_step = '0;
   logic [CHANNELS*DIV_WIDTH-1:0] i_div = '0;
   logic [LEN_WIDTH-1:0]          i_len = '0;
   logic [CHANNELS*WIDTH-1:0]     o_data;
   logic [CHANNELS-1:0]           o_valid;
   logic                          o_busy;
   logic                          o_done;

   int checks = 0;
   int failures = 0;

   pattern_gen #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DIV_WIDTH(DIV_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
      .i_mode(i_mode), .i_seed(i_seed), .i_step(i_step), .i_div(i_div), .i_len(i_len),
      .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if ({o_data, o_valid, o_busy, o_done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got data=%h valid=%b busy=%b done=%b want all zero", o_data, o_valid, o_busy, o_done);
      end
      i_rst = 1'b0;
      tick();
      checks++;
      if (o_busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_busy got %b want 0", o_busy);
      end
   endtask

   task automatic test_add_wrap();
      logic [7:0] exp [10] = '{8'd1, 8'd34, 8'd67, 8'd100, 8'd133, 8'd166, 8'd199, 8'd232, 8'd9, 8'd42};
      i_mode = 2'b00; i_seed = {8'd0, 8'd1}; i_step = {8'd0, 8'd33}; i_div = {8'd0, 8'd0}; i_len = 16'd10;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_busy !== 1'b1 || o_valid !== 2'b00) begin
         failures++;
         $display("FAIL add_load got busy=%b valid=%b want busy=1 valid=00", o_busy, o_valid);
      end
      tick();
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (o_data[7:0] !== exp[k] || o_valid[0] !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL add_wrap[%0d] got data=%0d valid0=%b busy=%b done=%b want data=%0d valid0=1 busy=1 done=0",
                     k, o_data[7:0], o_valid[0], o_busy, o_done, exp[k]);
         end
         // mid-burst start and config changes must be ignored
         if (k == 3) begin i_start = 1'b1; i_seed = {8'd0, 8'd77}; i_step = {8'd0, 8'd5}; end
         if (k == 4) i_start = 1'b0;
         tick();
      end
      checks++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 2'b00 || o_data[7:0] !== 8'd42) begin
         failures++;
         $display("FAIL add_done got done=%b busy=%b valid=%b data=%0d want done=1 busy=0 valid=00 data=42",
                  o_done, o_busy, o_valid, o_data[7:0]);
      end
      tick();
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_data[7:0] !== 8'd42) begin
         failures++;
         $display("FAIL add_after_done got done=%b busy=%b data=%0d want done=0 busy=0 data=42", o_done, o_busy, o_data[7:0]);
      end
      tick();
      checks++;
      if (o_busy !== 1'b0) begin
         failures++;
         $display("FAIL add_no_restart got busy=%b want 0", o_busy);
      end
   endtask

   task automatic test_shift_reload();
      logic [7:0] exp [9] = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1, 8'd200};
      i_mode = 2'b10; i_seed = {8'd200, 8'd0}; i_step = {8'd0, 8'd1}; i_div = {8'd1, 8'd0}; i_len = 16'd0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (o_data[15:8] !== exp[k] || o_valid[1] !== 1'b1) begin
            failures++;
            $display("FAIL shift[%0d] got data=%0d valid1=%b want data=%0d valid1=1", k, o_data[15:8], o_valid[1], exp[k]);
         end
         tick();
         checks++;
         if (o_data[15:8] !== exp[k] || o_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL shift_gap[%0d] got data=%0d valid1=%b want data=%0d valid1=0", k, o_data[15:8], o_valid[1], exp[k]);
         end
         tick();
      end
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_valid !== 2'b00 || o_done !== 1'b0 || o_data[15:8] !== 8'd100) begin
         failures++;
         $display("FAIL shift_stop got busy=%b valid=%b done=%b data1=%0d want busy=0 valid=00 done=0 data1=100",
                  o_busy, o_valid, o_done, o_data[15:8]);
      end
      tick();
   endtask

   task automatic test_mixed_rates();
      int busy_n = 0, v0_n = 0, v1_n = 0, p1 = -1, p2 = -1;
      i_mode = 2'b00; i_seed = {8'd10, 8'd0}; i_step = {8'd5, 8'd1}; i_div = {8'd3, 8'd0}; i_len = 16'd8;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int c = 0; c < 30 && o_done !== 1'b1; c++) begin
         if (o_busy === 1'b1) busy_n++;
         if (o_valid[0] === 1'b1) v0_n++;
         if (o_valid[1] === 1'b1) begin
            v1_n++;
            if (p1 < 0) p1 = c; else if (p2 < 0) p2 = c;
         end
         tick();
      end
      checks++;
      if (o_done !== 1'b1) begin
         failures++;
         $display("FAIL mixed_timeout got done=%b want 1 within 30 cycles", o_done);
      end
      checks++;
      if (busy_n != 9 || v0_n != 8 || v1_n != 2) begin
         failures++;
         $display("FAIL mixed_counts got busy=%0d v0=%0d v1=%0d want busy=9 v0=8 v1=2", busy_n, v0_n, v1_n);
      end
      checks++;
      if (p1 != 1 || p2 != 5) begin
         failures++;
         $display("FAIL mixed_ch1_pos got %0d,%0d want 1,5", p1, p2);
      end
      checks++;
      if (o_data !== {8'd15, 8'd7}) begin
         failures++;
         $display("FAIL mixed_final_data got %h want 0f07", o_data);
      end
      tick();
   endtask

   task automatic test_stop_priority();
      i_mode = 2'b00; i_seed = {8'd0, 8'd1}; i_step = {8'd0, 8'd33}; i_div = {8'd0, 8'd0}; i_len = 16'd10;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if (o_data[7:0] !== 8'd100 || o_valid[0] !== 1'b1) begin
         failures++;
         $display("FAIL stop_pre got data=%0d valid0=%b want data=100 valid0=1", o_data[7:0], o_valid[0]);
      end
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_valid !== 2'b00 || o_done !== 1'b0 || o_data[7:0] !== 8'd100) begin
         failures++;
         $display("FAIL stop_run got busy=%b valid=%b done=%b data=%0d want busy=0 valid=00 done=0 data=100",
                  o_busy, o_valid, o_done, o_data[7:0]);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (o_done !== 1'b0 || o_data[7:0] !== 8'd100) begin
            failures++;
            $display("FAIL stop_hold[%0d] got done=%b data=%0d want done=0 data=100", k, o_done, o_data[7:0]);
         end
      end
      i_start = 1'b1; i_stop = 1'b1;
      tick();
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_valid !== 2'b00) begin
         failures++;
         $display("FAIL start_stop_idle got busy=%b valid=%b want busy=0 valid=00", o_busy, o_valid);
      end
      i_start = 1'b0; i_stop = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      logic [7:0] exp [3] = '{8'd1, 8'd34, 8'd67};
      i_mode = 2'b00; i_seed = {8'd5, 8'd1}; i_step = {8'd1, 8'd33}; i_div = {8'd0, 8'd0}; i_len = 16'd0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      tick();
      #2 i_rst = 1'b1;
      #1;
      checks++;
      if ({o_data, o_valid, o_busy, o_done} !== '0) begin
         failures++;
         $display("FAIL async_reset got data=%h valid=%b busy=%b done=%b want all zero", o_data, o_valid, o_busy, o_done);
      end
      tick();
      i_rst = 1'b0;
      tick();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (o_data[7:0] !== exp[k] || o_valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_rerun[%0d] got data=%0d valid0=%b want data=%0d valid0=1", k, o_data[7:0], o_valid[0], exp[k]);
         end
         tick();
      end
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      tick();
   endtask

   task automatic test_saturate();
`ifdef PATGEN_SATURATE_EN
      logic [7:0] exp [4] = '{8'd200, 8'd233, 8'd255, 8'd255};
`else
      logic [7:0] exp [4] = '{8'd200, 8'd233, 8'd10, 8'd43};
`endif
      i_mode = 2'b00; i_seed = {8'd0, 8'd200}; i_step = {8'd0, 8'd33}; i_div = {8'd0, 8'd0}; i_len = 16'd4;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (o_data[7:0] !== exp[k]) begin
            failures++;
            $display("FAIL add_overflow[%0d] got %0d want %0d", k, o_data[7:0], exp[k]);
         end
         tick();
      end
      checks++;
      if (o_done !== 1'b1) begin
         failures++;
         $display("FAIL overflow_done got %b want 1", o_done);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_shift_reload();
      test_mixed_rates();
      test_stop_priority();
      test_async_reset();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
